fwd_scoreboard: RTL and testbench

Parametrised forwarding and hazard unit for the pipelined MIPS core: a registered scoreboard of in-flight destination registers that shifts with the pipeline. It sits beside the ID stage, produces per-operand forward-mux selects and the load-use / no-forward stall, and absorbs pipeline freezes (cache miss) and branch flushes without losing track of pending writes. Hit counters for stalls are kept for performance analysis.

---
 rtl/fwd_scoreboard.sv | 116 +++++++++++
 tb/tb_fwd_scoreboard.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: scoreboard of in-flight destination registers beside ID.
// Produces per-operand forward-mux selects, the load-use / interlock stall,
// and a saturating stall-cycle counter. Slot 0 = EX, slot 1 = MEM, ...
module fwd_scoreboard #(
    parameter int NSTAGE = 3,
    parameter int AW     = 5,
    parameter int FWD_EN = 1,
    parameter int SELW   = $clog2(NSTAGE + 2)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_pipe_en,
    input  logic            i_flush,
    input  logic            i_id_valid,
    input  logic [AW-1:0]   i_id_rs,
    input  logic [AW-1:0]   i_id_rt,
    input  logic            i_id_rs_used,
    input  logic            i_id_rt_used,
    input  logic            i_id_regwrite,
    input  logic            i_id_memread,
    input  logic [AW-1:0]   i_id_wa,
    output logic            o_stall,
    output logic            o_id_fire,
    output logic [SELW-1:0] o_fwd_sel_a,
    output logic [SELW-1:0] o_fwd_sel_b,
    output logic [31:0]     o_stall_cnt
);

    // Slot state: valid already includes regwrite, so a slot is live when
    // valid and its destination is not $0.
    logic [NSTAGE-1:0] r_v;
    logic [NSTAGE-1:0] r_ld;
    logic [AW-1:0]     r_wa [NSTAGE];
    logic [31:0]       r_stall_cnt;

    logic              w_haz_a;
    logic              w_haz_b;
    logic [SELW-1:0]   w_sel_a;
    logic [SELW-1:0]   w_sel_b;
    logic              w_stall;
    logic              w_fire;

    // Returns {hazard, select} for one source operand. Scanning oldest to
    // youngest lets the youngest match overwrite older ones; in interlock
    // mode the hazard bit is sticky so any match anywhere stalls.
    function automatic logic [SELW:0] f_lookup(input logic used, input logic [AW-1:0] src);
        logic            haz;
        logic [SELW-1:0] sel;
        haz = 1'b0;
        sel = '0;
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            if (used && r_v[k] && (r_wa[k] != '0) && (r_wa[k] == src)) begin
                if (FWD_EN == 0) begin
                    haz = 1'b1;
                    sel = '0;
                end else if ((k == 0) && r_ld[k]) begin
                    haz = 1'b1;
                    sel = '0;
                end else if ((k == 1) && r_ld[k]) begin
                    haz = 1'b0;
                    sel = SELW'(NSTAGE + 1);
                end else begin
                    haz = 1'b0;
                    sel = SELW'(k + 1);
                end
            end
        end
        return {haz, sel};
    endfunction

    // Combinational hazard detection and forward selection
    always_comb begin
        {w_haz_a, w_sel_a} = f_lookup(i_id_rs_used, i_id_rs);
        {w_haz_b, w_sel_b} = f_lookup(i_id_rt_used, i_id_rt);
        w_stall = i_id_valid && (w_haz_a || w_haz_b) && !i_flush;
        w_fire  = i_id_valid && !w_stall && i_pipe_en && !i_flush;
    end

    // Slot shift register: advances with the pipeline, holds on freeze,
    // and squashes the EX entry on a branch flush.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_v  <= '0;
            r_ld <= '0;
            for (int k = 0; k < NSTAGE; k++) r_wa[k] <= '0;
        end else if (i_pipe_en) begin
            for (int k = 1; k < NSTAGE; k++) begin
                r_v[k]  <= r_v[k-1];
                r_ld[k] <= r_ld[k-1];
                r_wa[k] <= r_wa[k-1];
            end
            r_v[0]  <= w_fire && i_id_regwrite;
            r_ld[0] <= i_id_memread;
            r_wa[0] <= i_id_wa;
            if (i_flush) r_v[1] <= 1'b0;
        end else if (i_flush) begin
            r_v[0] <= 1'b0;
        end
    end

    // Saturating count of stall cycles that actually cost a pipeline slot
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_stall && i_pipe_en && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign o_stall     = w_stall;
    assign o_id_fire   = w_fire;
    assign o_fwd_sel_a = w_sel_a;
    assign o_fwd_sel_b = w_sel_b;
    assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Bench for fwd_scoreboard: one forwarding instance and one interlock-only
// instance (both NSTAGE=3) driven from shared inputs, checked from vector
// tables plus hand-written reset sequences.
module tb_fwd_scoreboard;

    logic        clk;
    logic        rst_n;
    logic        pipe_en, flush, id_valid;
    logic [4:0]  id_rs, id_rt, id_wa;
    logic        id_rs_used, id_rt_used, id_regwrite, id_memread;

    logic        f_stall, f_fire, i_stall, i_fire;
    logic [2:0]  f_sel_a, f_sel_b, i_sel_a, i_sel_b;
    logic [31:0] f_cnt, i_cnt;

    int n_pass = 0;
    int n_tot  = 0;

    typedef struct {
        logic       pe, fl, v;
        logic [4:0] rs, rt;
        logic       rsu, rtu, rw, ld;
        logic [4:0] wa;
        logic       e_stall, e_fire;
        logic [2:0] e_sa, e_sb;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t fv[$];
    vec_t iv[$];

    fwd_scoreboard #(.NSTAGE(3), .AW(5), .FWD_EN(1)) u_fwd (
        .i_clk(clk), .i_rst_n(rst_n), .i_pipe_en(pipe_en), .i_flush(flush),
        .i_id_valid(id_valid), .i_id_rs(id_rs), .i_id_rt(id_rt),
        .i_id_rs_used(id_rs_used), .i_id_rt_used(id_rt_used),
        .i_id_regwrite(id_regwrite), .i_id_memread(id_memread), .i_id_wa(id_wa),
        .o_stall(f_stall), .o_id_fire(f_fire), .o_fwd_sel_a(f_sel_a),
        .o_fwd_sel_b(f_sel_b), .o_stall_cnt(f_cnt)
    );

    fwd_scoreboard #(.NSTAGE(3), .AW(5), .FWD_EN(0)) u_ilk (
        .i_clk(clk), .i_rst_n(rst_n), .i_pipe_en(pipe_en), .i_flush(flush),
        .i_id_valid(id_valid), .i_id_rs(id_rs), .i_id_rt(id_rt),
        .i_id_rs_used(id_rs_used), .i_id_rt_used(id_rt_used),
        .i_id_regwrite(id_regwrite), .i_id_memread(id_memread), .i_id_wa(id_wa),
        .o_stall(i_stall), .o_id_fire(i_fire), .o_fwd_sel_a(i_sel_a),
        .o_fwd_sel_b(i_sel_b), .o_stall_cnt(i_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic pe, logic fl, logic v, logic [4:0] rs, logic [4:0] rt,
                                logic rsu, logic rtu, logic rw, logic ld, logic [4:0] wa,
                                logic es, logic ef, logic [2:0] sa, logic [2:0] sb, logic [31:0] cnt);
        vec_t t;
        t.pe = pe; t.fl = fl; t.v = v; t.rs = rs; t.rt = rt;
        t.rsu = rsu; t.rtu = rtu; t.rw = rw; t.ld = ld; t.wa = wa;
        t.e_stall = es; t.e_fire = ef; t.e_sa = sa; t.e_sb = sb; t.e_cnt = cnt;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        else n_pass++;
    endtask

    task automatic drive(input vec_t t);
        pipe_en = t.pe; flush = t.fl; id_valid = t.v;
        id_rs = t.rs; id_rt = t.rt; id_rs_used = t.rsu; id_rt_used = t.rtu;
        id_regwrite = t.rw; id_memread = t.ld; id_wa = t.wa;
    endtask

    task automatic run_vec(input vec_t t, input bit ilk, input int idx);
        string p;
        @(negedge clk);
        drive(t);
        #1;
        p = ilk ? $sformatf("ilk%0d", idx) : $sformatf("fwd%0d", idx);
        if (ilk) begin
            chk({p, "_stall"}, 32'(i_stall), 32'(t.e_stall));
            chk({p, "_fire"},  32'(i_fire),  32'(t.e_fire));
            chk({p, "_sel_a"}, 32'(i_sel_a), 32'(t.e_sa));
            chk({p, "_sel_b"}, 32'(i_sel_b), 32'(t.e_sb));
            chk({p, "_cnt"},   i_cnt,        t.e_cnt);
        end else begin
            chk({p, "_stall"}, 32'(f_stall), 32'(t.e_stall));
            chk({p, "_fire"},  32'(f_fire),  32'(t.e_fire));
            chk({p, "_sel_a"}, 32'(f_sel_a), 32'(t.e_sa));
            chk({p, "_sel_b"}, 32'(f_sel_b), 32'(t.e_sb));
            chk({p, "_cnt"},   f_cnt,        t.e_cnt);
        end
    endtask

    initial begin
        //           pe fl v  rs  rt  rsu rtu rw ld wa  | stall fire sa sb cnt
        // reach-back over add $3, then chain of $5 through slots 1 and 2
        fv.push_back(mk(1,0,1, 1, 2, 1,1, 1,0, 3,  0,1,0,0,0));
        fv.push_back(mk(1,0,1, 3, 0, 1,0, 1,0,10,  0,1,1,0,0));
        fv.push_back(mk(1,0,0, 0, 0, 0,0, 0,0, 0,  0,0,0,0,0));
        fv.push_back(mk(1,0,1, 0, 0, 1,0, 1,0, 5,  0,1,0,0,0));
        fv.push_back(mk(1,0,0, 0, 0, 0,0, 0,0, 0,  0,0,0,0,0));
        fv.push_back(mk(1,0,1, 5, 5, 1,1, 1,0, 0,  0,1,2,2,0));
        fv.push_back(mk(1,0,1, 5, 0, 1,0, 0,0, 0,  0,1,3,0,0));
        fv.push_back(mk(1,0,1, 5, 0, 1,0, 0,0, 0,  0,1,0,0,0));
        // load-use: one stall, then memory-data select on both operands
        fv.push_back(mk(1,0,1, 1, 0, 1,0, 1,1, 8,  0,1,0,0,0));
        fv.push_back(mk(1,0,1, 8, 8, 1,1, 1,0, 9,  1,0,0,0,0));
        fv.push_back(mk(1,0,1, 8, 8, 1,1, 1,0, 9,  0,1,4,4,1));
        // freeze during a load-use stall, then five frozen cycles with load in MEM
        fv.push_back(mk(1,0,1, 9, 0, 1,0, 1,1, 8,  0,1,1,0,1));
        fv.push_back(mk(0,0,1, 8, 0, 1,0, 0,0, 0,  1,0,0,0,1));
        fv.push_back(mk(1,0,1, 8, 0, 1,0, 0,0, 0,  1,0,0,0,1));
        for (int i = 0; i < 5; i++)
            fv.push_back(mk(0,0,1, 8, 0, 1,0, 0,0, 0,  0,0,4,0,2));
        fv.push_back(mk(1,0,1, 8, 0, 1,0, 0,0, 0,  0,1,4,0,2));
        // flush squashes add $4 in EX
        fv.push_back(mk(1,0,1, 1, 0, 1,0, 1,0, 4,  0,1,0,0,2));
        fv.push_back(mk(1,1,1, 4, 0, 1,0, 1,0,15,  0,0,1,0,2));
        fv.push_back(mk(1,0,1, 4, 0, 1,0, 0,0, 0,  0,1,0,0,2));
        // flush coinciding with a load-use hazard
        fv.push_back(mk(1,0,1, 1, 0, 1,0, 1,1, 7,  0,1,0,0,2));
        fv.push_back(mk(1,1,1, 7, 0, 1,0, 1,0,16,  0,0,0,0,2));
        fv.push_back(mk(1,0,1, 7, 0, 1,0, 1,0,12,  0,1,0,0,2));
        // flush while frozen: only EX squashed, MEM entry ($12) survives
        fv.push_back(mk(1,0,1, 1, 0, 1,0, 1,0,11,  0,1,0,0,2));
        fv.push_back(mk(0,1,1,11, 0, 1,0, 0,0, 0,  0,0,1,0,2));
        fv.push_back(mk(1,0,1,11,12, 1,1, 1,1, 0,  0,1,0,2,2));
        // load to $0 never stalls or forwards
        fv.push_back(mk(1,0,1, 0, 0, 1,1, 0,0, 0,  0,1,0,0,2));
        fv.push_back(mk(1,0,1, 1, 0, 1,0, 1,0,14,  0,1,0,0,2));

        // interlock-only instance
        iv.push_back(mk(1,0,1, 1, 2, 1,1, 1,0, 6,  0,1,0,0,0));
        iv.push_back(mk(1,0,1, 6, 0, 1,0, 1,0,13,  1,0,0,0,0));
        iv.push_back(mk(1,0,1, 6, 0, 1,0, 1,0,13,  1,0,0,0,1));
        iv.push_back(mk(1,0,1, 6, 0, 1,0, 1,0,13,  1,0,0,0,2));
        iv.push_back(mk(1,0,1, 6, 0, 1,0, 1,0,13,  0,1,0,0,3));
        iv.push_back(mk(1,0,1, 1, 0, 1,0, 1,0, 0,  0,1,0,0,3));
        iv.push_back(mk(1,0,1, 0, 0, 1,1, 0,0, 0,  0,1,0,0,3));
        iv.push_back(mk(0,0,1,13, 0, 1,0, 0,0, 0,  1,0,0,0,3));
        iv.push_back(mk(1,0,1,13, 0, 1,0, 0,0, 0,  1,0,0,0,3));
        iv.push_back(mk(1,0,1,13, 0, 1,0, 0,0, 0,  0,1,0,0,4));

        // power-on reset with a reader of $3 presented in ID
        rst_n = 1'b0;
        drive(mk(1,0,1, 3, 0, 1,0, 0,0, 0,  0,0,0,0,0));
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_stall",  32'(f_stall), 32'd0);
        chk("rst_sel_a",  32'(f_sel_a), 32'd0);
        chk("rst_cnt",    f_cnt,        32'd0);
        chk("rst_fire",   32'(f_fire),  32'd1);
        rst_n = 1'b1;

        for (int i = 0; i < fv.size(); i++) run_vec(fv[i], 1'b0, i);

        // mid-operation async reset: $14 sits in EX, reader sees it, then reset clears it
        @(negedge clk);
        drive(mk(1,0,1,14, 0, 1,0, 0,0, 0,  0,0,0,0,0));
        #1;
        chk("pre_rst_sel_a", 32'(f_sel_a), 32'd1);
        chk("pre_rst_cnt",   f_cnt,        32'd2);
        rst_n = 1'b0;
        #1;
        chk("async_rst_sel_a", 32'(f_sel_a), 32'd0);
        chk("async_rst_cnt",   f_cnt,        32'd0);
        chk("async_rst_icnt",  i_cnt,        32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_sel_a", 32'(f_sel_a), 32'd0);
        chk("post_rst_stall", 32'(f_stall), 32'd0);
        chk("post_rst_fire",  32'(f_fire),  32'd1);

        for (int i = 0; i < iv.size(); i++) run_vec(iv[i], 1'b1, i);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
